id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high, matching `RestEn.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_bus  input  64  fetch packet: [63:32] PC, [31:0] instruction word.
REQ-005 in_valid  input  1  fetch packet valid.
REQ-006 in_ready  output  1  decode stage can accept a packet this cycle.
REQ-007 flush  input  1  synchronous pipeline flush (branch redirect).
REQ-008 out_valid  output  1  decoded packet valid toward EXE.
REQ-009 out_ready  input  1  EXE allows in.
REQ-010 out_pc  output  32  PC of head packet.
REQ-011 out_inst  output  32  raw instruction of head packet.
REQ-012 out_rd / out_rj / out_rk  output  5 each  inst[4:0] / inst[9:5] / inst[14:10].
REQ-013 out_imm  output  32  extended immediate per REQ-022.
REQ-014 out_class  output  3  0 INVALID, 1 ALU_REG, 2 ALU_IMM, 3 LUI, 4 MEM, 5 BRANCH.

Function
REQ-015 Accept (in_fire) SHALL be in_valid & in_ready; emit (out_fire) SHALL be out_valid & out_ready.
REQ-016 Storage SHALL be a 2-entry FIFO (head, tail) with count 0..2; out_valid = (count != 0); outputs decoded from head only.
REQ-017 in_ready SHALL be a registered signal equal to (count_next < 2); never combinationally dependent on out_ready.
REQ-018 Latency SHALL be one cycle: a packet accepted at edge N with count 0 is on outputs, out_valid=1, after edge N.
REQ-019 Simultaneous in_fire and out_fire SHALL leave count unchanged, head advances, new packet enters behind remaining entry; order strictly FIFO.
REQ-020 Decode SHALL be combinational on head: ALU_REG inst[31:15]=0x00020 (add.w); ALU_IMM inst[31:22]=0x00A (addi.w); LUI inst[31:25]=0x0A (lu12i.w); MEM inst[31:22]=0x0A2 (ld.w) or 0x0A6 (st.w); BRANCH inst[31:26] in 0x13..0x17 (jirl, b, bl, beq, bne); else INVALID.
REQ-021 Packet with class INVALID SHALL still flow through the FIFO unchanged.
REQ-022 out_imm: ALU_IMM/MEM sign-ext inst[21:10]; LUI {inst[24:5],12'b0}; jirl/beq/bne sign-ext {inst[25:10],2'b0}; b/bl sign-ext {inst[9:0],inst[25:10],2'b0}; ALU_REG/INVALID 0.
REQ-023 flush=1 SHALL set count to 0 at next edge, discard any same-cycle in_fire, and drive in_ready=1 after that edge.
REQ-024 Data path registers SHALL capture only on accept; no capture when count=2.

Reset
REQ-025 While reset=1: count=0, out_valid=0, in_ready=1, FIFO data registers cleared to 0, out_class=INVALID(0), out_imm=0.
REQ-026 Reset asserted mid-operation SHALL discard all held packets immediately, asynchronously.
REQ-027 First accept SHALL be possible at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro ID_SKID_EN SHALL select buffering.
REQ-029 With ID_SKID_EN defined: 2-entry FIFO, registered in_ready per REQ-016..REQ-019.
REQ-030 Without ID_SKID_EN: single entry; in_ready = ~out_valid | out_ready (combinational); accept-and-emit in same cycle replaces the entry; all other requirements unchanged.

Verification
REQ-031 Reset pulse -> out_valid=0, in_ready=1, out_class=0, out_imm=0x00000000.
REQ-032 in_bus={0x1C000000,0x02800421}, out_ready=1 -> next cycle out_pc=0x1C000000, class=2, rd=1, rj=1, imm=0x00000001.
REQ-033 inst 0x53FFFFFF (b, offs=-1) -> class=5, out_imm=0xFFFFFFFC; inst 0xFFFFFFFF -> class=0, imm=0.
REQ-034 ID_SKID_EN, out_ready=0, three valid packets PC 0x1C000000/04/08 -> first two accepted, in_ready=0, third held; release out_ready -> PCs emerge 00, 04, 08 in order, no loss or duplication.
REQ-035 count=2 with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, flushed and incoming packets never appear on outputs.
REQ-036 Random in_valid/out_ready over 10000 cycles, both macro settings -> output PC sequence equals accepted PC sequence, each packet exactly once.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage between fetch and EXE.
//
// Buffers fetch packets and decodes the head packet combinationally into
// register fields, an immediate and an instruction class.
//
// Configuration macro: ID_SKID_EN
//   defined   : 2-entry FIFO, in_ready registered (count_next < 2)
//   undefined : single entry, in_ready = ~out_valid | out_ready (combinational)
//
// Ports
//   clk        in   1   pipeline clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   in_bus     in  64   fetch packet: [63:32] PC, [31:0] instruction
//   in_valid   in   1   fetch packet valid
//   in_ready   out  1   stage can accept a packet this cycle
//   flush      in   1   synchronous flush (branch redirect)
//   out_valid  out  1   head packet valid toward EXE
//   out_ready  in   1   EXE accepts head packet
//   out_pc     out 32   PC of head packet
//   out_inst   out 32   raw instruction of head packet
//   out_rd     out  5   inst[4:0]
//   out_rj     out  5   inst[9:5]
//   out_rk     out  5   inst[14:10]
//   out_imm    out 32   extended immediate
//   out_class  out  3   0 INVALID, 1 ALU_REG, 2 ALU_IMM, 3 LUI, 4 MEM, 5 BRANCH
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_bus,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rj,
  output logic [4:0]  out_rk,
  output logic [31:0] out_imm,
  output logic [2:0]  out_class
);

  localparam int unsigned PKT_W = 64;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CLS_W = 3;

  localparam logic [CLS_W-1:0] CLS_INVALID = 3'd0;
  localparam logic [CLS_W-1:0] CLS_ALU_REG = 3'd1;
  localparam logic [CLS_W-1:0] CLS_ALU_IMM = 3'd2;
  localparam logic [CLS_W-1:0] CLS_LUI     = 3'd3;
  localparam logic [CLS_W-1:0] CLS_MEM     = 3'd4;
  localparam logic [CLS_W-1:0] CLS_BRANCH  = 3'd5;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BNE  = 6'h17;

  logic             in_fire;
  logic             out_fire;
  logic [PKT_W-1:0] head_q;
  logic [PKT_W-1:0] head_d;

`ifdef ID_SKID_EN
  // ---------------------------------------------------------------------------
  // Two-entry FIFO: head_q is presented, tail_q waits behind it.
  // ---------------------------------------------------------------------------
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic [PKT_W-1:0] tail_q;
  logic [PKT_W-1:0] tail_d;
  logic             in_ready_q;
  logic             in_ready_d;

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Next-state for occupancy and entry data.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      // Same-cycle accept is dropped along with the held packets.
      count_d = 2'd0;
    end else begin
      case ({in_fire, out_fire})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_bus;
          else                 tail_d = in_bus;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves; new packet slots in behind whatever remains.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = in_bus;
          end else begin
            head_d = in_bus;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = (count_d < 2'd2);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single entry: a packet may replace the head in the cycle it leaves.
  // ---------------------------------------------------------------------------
  logic valid_q;
  logic valid_d;

  assign out_valid = valid_q;
  assign in_ready  = ~valid_q | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state for the single entry.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      valid_d = 1'b1;
      head_d  = in_bus;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Head decode.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  inst;
  logic [5:0]       op6;
  logic [CLS_W-1:0] cls_c;
  logic [XLEN-1:0]  imm_c;

  assign inst     = head_q[31:0];
  assign op6      = inst[31:26];
  assign out_pc   = head_q[63:32];
  assign out_inst = inst;
  assign out_rd   = inst[4:0];
  assign out_rj   = inst[9:5];
  assign out_rk   = inst[14:10];

  // Class and immediate from opcode fields.
  always_comb begin
    cls_c = CLS_INVALID;
    imm_c = '0;
    if (inst[31:15] == 17'h00020) begin
      cls_c = CLS_ALU_REG;
    end else if (inst[31:22] == 10'h00A) begin
      cls_c = CLS_ALU_IMM;
      imm_c = {{20{inst[21]}}, inst[21:10]};
    end else if (inst[31:25] == 7'h0A) begin
      cls_c = CLS_LUI;
      imm_c = {inst[24:5], 12'h000};
    end else if ((inst[31:22] == 10'h0A2) || (inst[31:22] == 10'h0A6)) begin
      cls_c = CLS_MEM;
      imm_c = {{20{inst[21]}}, inst[21:10]};
    end else if ((op6 >= OP_JIRL) && (op6 <= OP_BNE)) begin
      cls_c = CLS_BRANCH;
      // b/bl carry a 26-bit offset split as {inst[9:0], inst[25:10]}.
      if ((op6 == OP_B) || (op6 == OP_BL))
        imm_c = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
      else
        imm_c = {{14{inst[25]}}, inst[25:10], 2'b00};
    end
  end

  assign out_class = cls_c;
  assign out_imm   = imm_c;

endmodule
